// File: rtl/ps2_rx_pkg.sv
// Shared types and frame constants for the PS/2 device-to-host receiver.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0]  PS2_EXT_CODE   = 8'hE0;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is only dropped
// (with a one-cycle overflow pulse) when no pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_data     = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && !w_do_push;
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronisers, frame FSM, timeout and byte FIFO.
// Optional break-code filtering is enabled by defining PS2_RX_BREAK_FILTER_EN.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0]   r_clk_sync;
  logic [SYNC_STAGES-1:0]   r_data_sync;
  logic                     r_clk_prev;
  ps2_state_t               r_state;
  logic [2:0]               r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_parity;
  logic [TW-1:0]            r_timer;
  logic                     r_parity_err;
  logic                     r_frame_err;
`ifdef PS2_RX_BREAK_FILTER_EN
  logic                     r_break_pending;
`endif

  logic w_clk_s;
  logic w_data_s;
  logic w_edge;
  logic w_timeout;
  logic w_parity_ok;
  logic w_push;
  logic w_empty;

  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s    = r_data_sync[SYNC_STAGES-1];
  assign w_edge      = r_clk_prev && !w_clk_s;
  assign w_timeout   = (r_state != ST_IDLE) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
  assign w_parity_ok = ^{r_shift, r_parity};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  // Push is decided combinationally in the stop-bit edge cycle so the byte
  // lands in the FIFO at the end of that cycle.
  always_comb begin
    w_push = w_edge && (r_state == ST_STOP) && w_data_s && w_parity_ok;
`ifdef PS2_RX_BREAK_FILTER_EN
    w_push = w_push && !r_break_pending && (r_shift != PS2_BREAK_CODE);
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_parity        <= 1'b0;
      r_timer         <= '0;
      r_parity_err    <= 1'b0;
      r_frame_err     <= 1'b0;
`ifdef PS2_RX_BREAK_FILTER_EN
      r_break_pending <= 1'b0;
`endif
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      if (r_state == ST_IDLE || w_edge) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_edge) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_data_s) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_data_s, r_shift[PS2_DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_parity <= w_data_s;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!w_data_s) begin
              r_frame_err <= 1'b1;
            end else if (!w_parity_ok) begin
              r_parity_err <= 1'b1;
            end
`ifdef PS2_RX_BREAK_FILTER_EN
            if (!w_data_s || !w_parity_ok || r_break_pending) begin
              r_break_pending <= 1'b0;
            end else if (r_shift == PS2_BREAK_CODE) begin
              r_break_pending <= 1'b1;
            end
`endif
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
`ifdef PS2_RX_BREAK_FILTER_EN
        r_break_pending <= 1'b0;
`endif
      end
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_data     (r_shift),
    .i_pop      (i_ready),
    .o_data     (o_data),
    .o_empty    (w_empty),
    .o_overflow (o_overflow)
  );

  assign o_valid      = !w_empty;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frame table plus latency, overflow, timeout,
// reset and break-code sequences (honours PS2_RX_BREAK_FILTER_EN).
module tb_ps2_rx;

  localparam int HALF    = 8;
  localparam int TIMEOUT = 4096;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_overflow;
  logic       o_busy;

  ps2_rx #(
    .SYNC_STAGES    (2),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_data   (i_ps2_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overflow   (o_overflow),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf  = 0;
  logic [7:0] popq[$];

  always @(negedge i_clk) begin
    if (o_parity_err) n_perr++;
    if (o_frame_err)  n_ferr++;
    if (o_overflow)   n_ovf++;
    if (o_valid && i_ready) popq.push_back(o_data);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b, input bit rdy_late);
    i_ps2_data = b;
    repeat (HALF) tick();
    i_ps2_clk = 1'b0;
    if (rdy_late) begin
      tick();
      tick();
      i_ready = 1'b1;
      repeat (HALF - 2) tick();
    end else begin
      repeat (HALF) tick();
    end
    i_ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int first, input int last, input bit rdy_late);
    for (int i = first; i <= last; i++) begin
      ps2_bit(fr[i], rdy_late && (i == last));
    end
    i_ps2_data = 1'b1;
  endtask

  task automatic wait_ferr(input int base, output int cycles);
    cycles = 0;
    for (int c = 0; c < 6000; c++) begin
      tick();
      cycles++;
      if (n_ferr != base) break;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pflip;
    logic       stop;
    logic       exp_pop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int b_pop, b_perr, b_ferr, b_ovf, cyc;
    logic [7:0] got;
    logic [7:0] brk_exp[4];
    int brk_n;

    vecs[0] = '{8'h08, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    i_rst = 1'b1; i_ps2_clk = 1'b1; i_ps2_data = 1'b1; i_ready = 1'b0;
    repeat (4) tick();
    chk("rst_data", o_data, 8'h00);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_perr", o_parity_err, 1'b0);
    chk("rst_ferr", o_frame_err, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    i_rst = 1'b0;
    repeat (4) tick();

    // Latency: byte visible exactly three cycles after the stop-bit fall is driven
    i_ready = 1'b1;
    send_bits(mk(8'h08, 1'b0, 1'b1), 0, 9, 1'b0);
    i_ps2_data = 1'b1;
    repeat (HALF) tick();
    i_ps2_clk = 1'b0;
    tick(); tick();
    chk("lat_before", o_valid, 1'b0);
    tick();
    chk("lat_valid", o_valid, 1'b1);
    chk("lat_data", o_data, 8'h08);
    tick();
    chk("lat_popped", o_valid, 1'b0);
    repeat (HALF - 4) tick();
    i_ps2_clk = 1'b1;
    repeat (HALF) tick();

    for (int i = 0; i < 8; i++) begin
      b_pop = popq.size(); b_perr = n_perr; b_ferr = n_ferr;
      send_bits(mk(vecs[i].d, vecs[i].pflip, vecs[i].stop), 0, 10, 1'b0);
      repeat (12) tick();
      got = (popq.size() > b_pop) ? popq[b_pop] : 8'h00;
      chk($sformatf("vec%0d_npop", i), popq.size() - b_pop, {31'd0, vecs[i].exp_pop});
      chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
      chk($sformatf("vec%0d_perr", i), n_perr - b_perr, {31'd0, vecs[i].exp_perr});
      chk($sformatf("vec%0d_ferr", i), n_ferr - b_ferr, {31'd0, vecs[i].exp_ferr});
      chk($sformatf("vec%0d_busy", i), o_busy, 1'b0);
    end

    // Overflow: five bytes into a four-entry FIFO with the consumer stalled
    i_ready = 1'b0;
    b_ovf = n_ovf; b_pop = popq.size();
    for (int k = 1; k <= 4; k++) send_bits(mk(8'(k), 1'b0, 1'b1), 0, 10, 1'b0);
    repeat (6) tick();
    chk("ovf_none_at4", n_ovf - b_ovf, 0);
    chk("ovf_head", o_data, 8'h01);
    send_bits(mk(8'h05, 1'b0, 1'b1), 0, 10, 1'b0);
    repeat (6) tick();
    chk("ovf_at5", n_ovf - b_ovf, 1);
    i_ready = 1'b1;
    repeat (10) tick();
    chk("ovf_drain_n", popq.size() - b_pop, 4);
    for (int k = 0; k < 4; k++) begin
      got = (popq.size() > b_pop + k) ? popq[b_pop + k] : 8'h00;
      chk($sformatf("ovf_drain%0d", k), got, 8'(k + 1));
    end

    // Full FIFO with push and pop landing on the same edge
    i_ready = 1'b0;
    b_ovf = n_ovf; b_pop = popq.size();
    for (int k = 0; k < 4; k++) send_bits(mk(8'(8'h11 + k), 1'b0, 1'b1), 0, 10, 1'b0);
    send_bits(mk(8'h15, 1'b0, 1'b1), 0, 10, 1'b1);
    repeat (12) tick();
    chk("pp_ovf", n_ovf - b_ovf, 0);
    chk("pp_n", popq.size() - b_pop, 5);
    for (int k = 0; k < 5; k++) begin
      got = (popq.size() > b_pop + k) ? popq[b_pop + k] : 8'h00;
      chk($sformatf("pp_data%0d", k), got, 8'(8'h11 + k));
    end

    // Timeout after four data bits, then recovery
    b_ferr = n_ferr; b_perr = n_perr; b_pop = popq.size();
    send_bits(mk(8'h08, 1'b0, 1'b1), 0, 4, 1'b0);
    chk("to_busy", o_busy, 1'b1);
    wait_ferr(b_ferr, cyc);
    chk("to_fired", n_ferr - b_ferr, 1);
    chk("to_window", (cyc >= TIMEOUT - 100) && (cyc <= TIMEOUT + 100), 1'b1);
    tick();
    chk("to_idle", o_busy, 1'b0);
    chk("to_nopop", popq.size() - b_pop, 0);
    send_bits(mk(8'h08, 1'b0, 1'b1), 0, 10, 1'b0);
    repeat (12) tick();
    chk("to_rec_n", popq.size() - b_pop, 1);
    got = (popq.size() > b_pop) ? popq[b_pop] : 8'h00;
    chk("to_rec_data", got, 8'h08);
    chk("to_perr", n_perr - b_perr, 0);

    // Reset mid-frame drops buffered byte; trailing bits form a garbage frame
    i_ready = 1'b0;
    send_bits(mk(8'h08, 1'b0, 1'b1), 0, 10, 1'b0);
    repeat (6) tick();
    chk("mr_buffered", o_valid, 1'b1);
    send_bits(mk(8'h08, 1'b0, 1'b1), 0, 3, 1'b0);
    chk("mr_busy", o_busy, 1'b1);
    i_rst = 1'b1;
    tick();
    chk("mr_rst_valid", o_valid, 1'b0);
    chk("mr_rst_busy", o_busy, 1'b0);
    i_rst = 1'b0;
    i_ready = 1'b1;
    tick();
    b_ferr = n_ferr; b_perr = n_perr; b_pop = popq.size();
    send_bits(mk(8'h08, 1'b0, 1'b1), 4, 10, 1'b0);
    wait_ferr(b_ferr, cyc);
    repeat (4) tick();
    chk("mr_ferr", n_ferr - b_ferr, 1);
    chk("mr_perr", n_perr - b_perr, 0);
    chk("mr_nopop", popq.size() - b_pop, 0);
    chk("mr_idle", o_busy, 1'b0);

    // Break-code sequence
`ifdef PS2_RX_BREAK_FILTER_EN
    brk_exp[0] = 8'h1C; brk_exp[1] = 8'h32; brk_exp[2] = 8'h00; brk_exp[3] = 8'h00;
    brk_n = 2;
`else
    brk_exp[0] = 8'h1C; brk_exp[1] = 8'hF0; brk_exp[2] = 8'h1C; brk_exp[3] = 8'h32;
    brk_n = 4;
`endif
    b_pop = popq.size();
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
    send_bits(mk(8'hF0, 1'b0, 1'b1), 0, 10, 1'b0);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
    send_bits(mk(8'h32, 1'b0, 1'b1), 0, 10, 1'b0);
    repeat (12) tick();
    chk("brk_n", popq.size() - b_pop, brk_n);
    for (int k = 0; k < brk_n; k++) begin
      got = (popq.size() > b_pop + k) ? popq[b_pop + k] : 8'h00;
      chk($sformatf("brk_data%0d", k), got, brk_exp[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
